ssd_scan_ctrl: RTL

//  Front end for the seven-segment display. Converts a 16-bit two's-complement sample into

---
 rtl/ssd_scan_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - sample-to-digit converter and 4-digit SSD scan multiplexer
// Hex digits are committed directly; decimal runs a 10-step sequential double-dabble.
module ssd_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int SAT_LIMIT   = 999
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] data_in,
    input  logic        mode_in,
    input  logic        load,
    output logic        load_ready,
    output logic        done,
    output logic [3:0]  num_out,
    output logic [1:0]  control,
    output logic        display_sel,
    output logic [3:0]  anode
);

    localparam int              CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [15:0]      SAT16   = 16'(SAT_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       data_q, data_d;
    logic              mode_q, mode_d;
    logic [21:0]       shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        dig0_q, dig0_d, dig1_q, dig1_d, dig2_q, dig2_d, dig3_q, dig3_d;
    logic              sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        control_q, control_d;
    logic [3:0]        anode_q, anode_d;

    logic [15:0]       abs_in;
    logic [9:0]        mag_in;
    logic [21:0]       dd_adj;

    // Magnitude is clamped on capture; 16'h8000 negates to itself and still exceeds the limit.
    always_comb begin
        abs_in = data_in[15] ? (~data_in + 16'd1) : data_in;
        mag_in = (abs_in > SAT16) ? SAT16[9:0] : abs_in[9:0];
    end

    // shift_q = {hundreds, tens, ones, binary}; add-3 correction precedes each shift.
    always_comb begin
        dd_adj = shift_q;
        if (dd_adj[13:10] >= 4'd5) dd_adj[13:10] = dd_adj[13:10] + 4'd3;
        if (dd_adj[17:14] >= 4'd5) dd_adj[17:14] = dd_adj[17:14] + 4'd3;
        if (dd_adj[21:18] >= 4'd5) dd_adj[21:18] = dd_adj[21:18] + 4'd3;
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        mode_d    = mode_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dig0_d    = dig0_q;
        dig1_d    = dig1_q;
        dig2_d    = dig2_q;
        dig3_d    = dig3_q;
        sel_d     = sel_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    data_d    = data_in;
                    mode_d    = mode_in;
                    busy_d    = 1'b1;
                    shift_d   = {12'd0, mag_in};
                    bit_cnt_d = 4'd0;
                    state_d   = mode_in ? CONV : COMMIT;
                end
            end
            CONV: begin
                shift_d   = {dd_adj[20:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd9) state_d = COMMIT;
            end
            COMMIT: begin
                if (mode_q) begin
                    dig0_d = shift_q[13:10];
                    dig1_d = shift_q[17:14];
                    dig2_d = shift_q[21:18];
                    dig3_d = data_q[15] ? 4'hF : 4'hA;
                end else begin
                    dig0_d = data_q[3:0];
                    dig1_d = data_q[7:4];
                    dig2_d = data_q[11:8];
                    dig3_d = data_q[15:12];
                end
                sel_d   = mode_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan runs free of the FSM so the display never stalls during a conversion.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        control_d = control_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d     = '0;
            control_d = control_q + 2'd1;
        end
        anode_d = ~(4'b0001 << control_d);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            data_q    <= 16'd0;
            mode_q    <= 1'b0;
            shift_q   <= 22'd0;
            bit_cnt_q <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dig0_q    <= 4'h0;
            dig1_q    <= 4'h0;
            dig2_q    <= 4'h0;
            dig3_q    <= 4'hA;
            sel_q     <= 1'b1;
            cnt_q     <= '0;
            control_q <= 2'd0;
            anode_q   <= 4'b1110;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dig0_q    <= dig0_d;
            dig1_q    <= dig1_d;
            dig2_q    <= dig2_d;
            dig3_q    <= dig3_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            control_q <= control_d;
            anode_q   <= anode_d;
        end
    end

    always_comb begin
        case (control_q)
            2'd0:    num_out = dig0_q;
            2'd1:    num_out = dig1_q;
            2'd2:    num_out = dig2_q;
            default: num_out = dig3_q;
        endcase
    end

    assign load_ready  = ~busy_q;
    assign done        = done_q;
    assign control     = control_q;
    assign display_sel = sel_q;
    assign anode       = anode_q;

endmodule
